// File: rtl/hazard_fwd_ctrl.sv
// Hazard detection and operand-forwarding control for a five-stage MIPS pipeline.
// Shadow E/M/W registers track each in-flight write's destination and cycles until its result is ready.
module hazard_fwd_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] D_rs,
    input  logic [4:0] D_rt,
    input  logic       D_use_rs,
    input  logic       D_use_rt,
    input  logic [1:0] D_tuse_rs,
    input  logic [1:0] D_tuse_rt,
    input  logic [4:0] D_wa,
    input  logic [1:0] D_tnew,
    output logic       stall,
    output logic [1:0] D_rs_sel,
    output logic [1:0] D_rt_sel,
    output logic [1:0] E_rs_sel,
    output logic [1:0] E_rt_sel
);

    logic [4:0] e_wa_reg, e_rs_reg, e_rt_reg, m_wa_reg, w_wa_reg;
    logic [1:0] e_tnew_reg, m_tnew_reg;

    // Operand 0 is rs and operand 1 is rt.
    logic [4:0] d_src  [2];
    logic       d_use  [2];
    logic [1:0] d_tuse [2];
    logic [4:0] e_src  [2];
    logic [1:0] d_sel  [2];
    logic [1:0] e_sel  [2];
    logic [1:0] op_stall;

    assign d_src[0]  = D_rs;
    assign d_src[1]  = D_rt;
    assign d_use[0]  = D_use_rs;
    assign d_use[1]  = D_use_rt;
    assign d_tuse[0] = D_tuse_rs;
    assign d_tuse[1] = D_tuse_rt;
    assign e_src[0]  = e_rs_reg;
    assign e_src[1]  = e_rt_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_op
            logic d_hit_e, d_hit_m, e_hit_m, e_hit_w;

            assign d_hit_e = (d_src[gi] != 5'd0) && (d_src[gi] == e_wa_reg);
            assign d_hit_m = (d_src[gi] != 5'd0) && (d_src[gi] == m_wa_reg);
            assign e_hit_m = (e_src[gi] != 5'd0) && (e_src[gi] == m_wa_reg);
            assign e_hit_w = (e_src[gi] != 5'd0) && (e_src[gi] == w_wa_reg);

            assign op_stall[gi] = d_use[gi] &&
                                  ((d_hit_e && (e_tnew_reg > d_tuse[gi])) ||
                                   (d_hit_m && (m_tnew_reg > d_tuse[gi])));

            // A younger producer in E shadows M even when its value is not ready yet.
            assign d_sel[gi] = d_hit_e ? ((e_tnew_reg == 2'd0) ? 2'd1 : 2'd0)
                             : (d_hit_m && (m_tnew_reg == 2'd0)) ? 2'd2 : 2'd0;

            assign e_sel[gi] = (e_hit_m && (m_tnew_reg == 2'd0)) ? 2'd1
                             : e_hit_w ? 2'd2 : 2'd0;
        end
    endgenerate

    assign stall    = |op_stall;
    assign D_rs_sel = d_sel[0];
    assign D_rt_sel = d_sel[1];
    assign E_rs_sel = e_sel[0];
    assign E_rt_sel = e_sel[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_wa_reg   <= 5'd0;
            e_rs_reg   <= 5'd0;
            e_rt_reg   <= 5'd0;
            e_tnew_reg <= 2'd0;
            m_wa_reg   <= 5'd0;
            m_tnew_reg <= 2'd0;
            w_wa_reg   <= 5'd0;
        end else begin
            if (stall) begin
                e_wa_reg   <= 5'd0;
                e_rs_reg   <= 5'd0;
                e_rt_reg   <= 5'd0;
                e_tnew_reg <= 2'd0;
            end else begin
                e_wa_reg   <= D_wa;
                e_rs_reg   <= D_rs;
                e_rt_reg   <= D_rt;
                e_tnew_reg <= D_tnew;
            end
            m_wa_reg   <= e_wa_reg;
            m_tnew_reg <= (e_tnew_reg == 2'd0) ? 2'd0 : e_tnew_reg - 2'd1;
            w_wa_reg   <= m_wa_reg;
        end
    end

endmodule
